// File: rtl/clock_set_ctrl.sv
// ---------------------------------------------------------------------------
// clock_set_ctrl
//
// Sequencing and setting controller for an HH:MM:SS timekeeping counter.
// It is the only source of the counter's 1 Hz advance pulse and of its
// parallel-load path. Two debounced buttons drive a mode FSM that lets the
// user edit the time and an alarm HH:MM. The edited time is written into
// the counter with a single load strobe. An alarm output is raised when the
// running time reaches the stored alarm time.
//
// Parameters
//   TICK_DIV    clk cycles per tick_en pulse (minimum 2)
//   REPEAT_DLY  clk cycles inc_btn must be held before the first auto-repeat,
//               and the spacing between later repeats
//   ALARM_SECS  tick_en pulses after which alarm_out clears by itself
//
// Ports
//   clk        in   system clock, all state updates on the rising edge
//   rst        in   asynchronous reset, active low
//   mode_btn   in   debounced level, rising edge = mode event
//   inc_btn    in   debounced level, rising edge = increment event
//   alarm_en   in   alarm armed while high
//   cur_hh     in   current hours from the counter (0..23)
//   cur_mm     in   current minutes (0..59)
//   cur_ss     in   current seconds (0..59)
//   tick_en    out  one-cycle advance pulse to the counter
//   load_en    out  one-cycle parallel-load strobe to the counter
//   load_hh    out  hours load value
//   load_mm    out  minutes load value
//   load_ss    out  seconds load value, always 0
//   disp_hh    out  hours to display
//   disp_mm    out  minutes to display
//   mode       out  encoded FSM state
//   alarm_out  out  alarm active
// ---------------------------------------------------------------------------
module clock_set_ctrl #(
   parameter int TICK_DIV   = 50000000,
   parameter int REPEAT_DLY = 25000000,
   parameter int ALARM_SECS = 60
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       mode_btn,
   input  logic       inc_btn,
   input  logic       alarm_en,
   input  logic [4:0] cur_hh,
   input  logic [5:0] cur_mm,
   input  logic [5:0] cur_ss,
   output logic       tick_en,
   output logic       load_en,
   output logic [4:0] load_hh,
   output logic [5:0] load_mm,
   output logic [5:0] load_ss,
   output logic [4:0] disp_hh,
   output logic [5:0] disp_mm,
   output logic [2:0] mode,
   output logic       alarm_out
);

   localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam int RW = $clog2(REPEAT_DLY + 1);
   localparam int AW = (ALARM_SECS > 2) ? $clog2(ALARM_SECS) : 1;

   typedef enum logic [2:0] {
      RUN     = 3'd0,
      SET_HR  = 3'd1,
      SET_MIN = 3'd2,
      AL_HR   = 3'd3,
      AL_MIN  = 3'd4
   } state_t;

   state_t        state;
   state_t        state_next;

   logic          mode_prev;
   logic          inc_prev;
   logic [PW-1:0] presc;
   logic [RW-1:0] rep_cnt;
   logic [AW-1:0] alarm_cnt;
   logic [4:0]    edit_hh;
   logic [5:0]    edit_mm;
   logic [4:0]    al_hh;
   logic [5:0]    al_mm;
   logic          match_prev;

   logic          mode_rise;
   logic          inc_rise;
   logic          btn_rise;
   logic          consume;
   logic          mode_ev;
   logic          rep_hit;
   logic          inc_ev;
   logic          in_set;
   logic          hold;
   logic          match;
   logic          alarm_set;
   logic          alarm_clr;

   function automatic logic [4:0] next_hour(input logic [4:0] h);
      return (h == 5'd23) ? 5'd0 : h + 5'd1;
   endfunction

   function automatic logic [5:0] next_minute(input logic [5:0] m);
      return (m == 6'd59) ? 6'd0 : m + 6'd1;
   endfunction

   // Event decode. A button edge that arrives while the alarm is sounding
   // only silences the alarm and is otherwise thrown away. A mode event
   // beats an increment (edge or auto-repeat) in the same cycle.
   assign mode_rise = mode_btn & ~mode_prev;
   assign inc_rise  = inc_btn & ~inc_prev;
   assign btn_rise  = mode_rise | inc_rise;
   assign consume   = alarm_out & btn_rise;
   assign mode_ev   = mode_rise & ~consume;
   assign rep_hit   = inc_btn & inc_prev & (rep_cnt == RW'(REPEAT_DLY));
   assign inc_ev    = (inc_rise | rep_hit) & ~consume & ~mode_ev;

   assign in_set    = (state == SET_HR) || (state == SET_MIN);

   // The counter is frozen while the time is being edited. The prescaler is
   // also held through the load cycle so that the first tick after a load
   // lands a full TICK_DIV cycles after the strobe.
   assign hold      = in_set || load_en;
   assign tick_en   = !hold && (presc == PW'(TICK_DIV - 1));

   assign load_ss   = 6'd0;
   assign mode      = state;

   // Alarm match is suppressed while editing so that a transient edit value
   // cannot trigger it.
   assign match     = alarm_en && !in_set && (cur_hh == al_hh) &&
                      (cur_mm == al_mm) && (cur_ss == 6'd0);
   assign alarm_set = match && !match_prev;
   assign alarm_clr = !alarm_en || btn_rise ||
                      (alarm_out && tick_en && (alarm_cnt == AW'(ALARM_SECS - 1)));

   // Mode FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= RUN;
      end else begin
         state <= state_next;
      end
   end

   // Mode FSM next state: each accepted mode event steps round the ring.
   always_comb begin
      state_next = state;
      if (mode_ev) begin
         case (state)
            RUN:     state_next = SET_HR;
            SET_HR:  state_next = SET_MIN;
            SET_MIN: state_next = AL_HR;
            AL_HR:   state_next = AL_MIN;
            AL_MIN:  state_next = RUN;
            default: state_next = RUN;
         endcase
      end
   end

   // Previous button levels for edge detection. Cleared by reset so a
   // button held through reset release is seen as a fresh press.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mode_prev <= 1'b0;
         inc_prev  <= 1'b0;
      end else begin
         mode_prev <= mode_btn;
         inc_prev  <= inc_btn;
      end
   end

   // Time-base prescaler producing the one-second advance pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         presc <= '0;
      end else if (hold) begin
         presc <= '0;
      end else if (presc == PW'(TICK_DIV - 1)) begin
         presc <= '0;
      end else begin
         presc <= presc + PW'(1);
      end
   end

   // Auto-repeat timer. It holds the number of cycles inc_btn has been
   // high since the press (or since the last repeat), so it reads
   // REPEAT_DLY exactly on the cycle a repeat is due. Restarting at 1 after
   // a hit keeps the repeat spacing at REPEAT_DLY.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rep_cnt <= '0;
      end else if (!inc_btn || mode_ev) begin
         rep_cnt <= '0;
      end else if (rep_hit) begin
         rep_cnt <= RW'(1);
      end else begin
         rep_cnt <= rep_cnt + RW'(1);
      end
   end

   // Edit copy of the time: captured from the counter on entry to SET_HR,
   // then adjusted by increments in the two SET modes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         edit_hh <= 5'd0;
         edit_mm <= 6'd0;
      end else if (mode_ev && (state == RUN)) begin
         edit_hh <= cur_hh;
         edit_mm <= cur_mm;
      end else if (inc_ev) begin
         if (state == SET_HR) begin
            edit_hh <= next_hour(edit_hh);
         end
         if (state == SET_MIN) begin
            edit_mm <= next_minute(edit_mm);
         end
      end
   end

   // Stored alarm time, adjusted only in the two alarm modes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         al_hh <= 5'd0;
         al_mm <= 6'd0;
      end else if (inc_ev) begin
         if (state == AL_HR) begin
            al_hh <= next_hour(al_hh);
         end
         if (state == AL_MIN) begin
            al_mm <= next_minute(al_mm);
         end
      end
   end

   // Parallel load into the counter, issued only when leaving SET_MIN.
   // The load values stay put between loads.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         load_en <= 1'b0;
         load_hh <= 5'd0;
         load_mm <= 6'd0;
      end else begin
         load_en <= mode_ev && (state == SET_MIN);
         if (mode_ev && (state == SET_MIN)) begin
            load_hh <= edit_hh;
            load_mm <= edit_mm;
         end
      end
   end

   // Alarm output. It sets on the rising edge of the match condition and
   // counts ticks while active so that it can time out. Every clear source
   // takes priority over a set in the same cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         match_prev <= 1'b0;
         alarm_out  <= 1'b0;
         alarm_cnt  <= '0;
      end else begin
         match_prev <= match;
         if (alarm_clr) begin
            alarm_out <= 1'b0;
            alarm_cnt <= '0;
         end else if (alarm_set) begin
            alarm_out <= 1'b1;
            alarm_cnt <= '0;
         end else if (alarm_out && tick_en) begin
            alarm_cnt <= alarm_cnt + AW'(1);
         end
      end
   end

   // Display mux: the value being edited, the alarm time, or the live time.
   always_comb begin
      disp_hh = cur_hh;
      disp_mm = cur_mm;
      case (state)
         SET_HR, SET_MIN: begin
            disp_hh = edit_hh;
            disp_mm = edit_mm;
         end
         AL_HR, AL_MIN: begin
            disp_hh = al_hh;
            disp_mm = al_mm;
         end
         default: begin
            disp_hh = cur_hh;
            disp_mm = cur_mm;
         end
      endcase
   end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clock_set_ctrl
//
// Directed bench for clock_set_ctrl with a short prescaler, repeat delay and
// alarm timeout. Expected load transactions go into a queue as the mode
// press that should cause them is driven; a negedge monitor pops and
// compares them whenever load_en appears.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_clock_set_ctrl;

   logic       clk;
   logic       rst;
   logic       mode_btn;
   logic       inc_btn;
   logic       alarm_en;
   logic [4:0] cur_hh;
   logic [5:0] cur_mm;
   logic [5:0] cur_ss;
   logic       tick_en;
   logic       load_en;
   logic [4:0] load_hh;
   logic [5:0] load_mm;
   logic [5:0] load_ss;
   logic [4:0] disp_hh;
   logic [5:0] disp_mm;
   logic [2:0] mode;
   logic       alarm_out;

   int         checks = 0;
   int         errors = 0;
   int         loads_seen = 0;
   logic       in_set_phase = 1'b0;
   logic [10:0] load_q[$];
   logic [10:0] exp_load;
   int         gap;
   int         ticks;
   int         gone;

   clock_set_ctrl #(
      .TICK_DIV   (4),
      .REPEAT_DLY (8),
      .ALARM_SECS (3)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .mode_btn  (mode_btn),
      .inc_btn   (inc_btn),
      .alarm_en  (alarm_en),
      .cur_hh    (cur_hh),
      .cur_mm    (cur_mm),
      .cur_ss    (cur_ss),
      .tick_en   (tick_en),
      .load_en   (load_en),
      .load_hh   (load_hh),
      .load_mm   (load_mm),
      .load_ss   (load_ss),
      .disp_hh   (disp_hh),
      .disp_mm   (disp_mm),
      .mode      (mode),
      .alarm_out (alarm_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // One press: level high for one cycle, then low for one cycle.
   task automatic apply_stimulus(input logic m, input logic i);
      mode_btn = m;
      inc_btn  = i;
      next_cycle();
      mode_btn = 1'b0;
      inc_btn  = 1'b0;
      next_cycle();
   endtask

   // Load scoreboard and frozen-time-base monitor.
   always @(negedge clk) begin
      if (in_set_phase) begin
         check_output("tick_frozen", 32'(tick_en), 32'd0);
      end
      if (load_en === 1'b1) begin
         loads_seen++;
         if (load_q.size() == 0) begin
            check_output("load_unexpected", 32'(load_en), 32'd0);
         end else begin
            exp_load = load_q.pop_front();
            check_output("load_hh", 32'(load_hh), 32'(exp_load[10:6]));
            check_output("load_mm", 32'(load_mm), 32'(exp_load[5:0]));
            check_output("load_ss", 32'(load_ss), 32'd0);
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: observed timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst      = 1'b0;
      mode_btn = 1'b0;
      inc_btn  = 1'b0;
      alarm_en = 1'b0;
      cur_hh   = 5'd0;
      cur_mm   = 6'd0;
      cur_ss   = 6'd0;

      // Reset state
      #12;
      check_output("rst_mode", 32'(mode), 32'd0);
      check_output("rst_tick", 32'(tick_en), 32'd0);
      check_output("rst_load_en", 32'(load_en), 32'd0);
      check_output("rst_load_hh", 32'(load_hh), 32'd0);
      check_output("rst_load_mm", 32'(load_mm), 32'd0);
      check_output("rst_alarm", 32'(alarm_out), 32'd0);
      #5 rst = 1'b1;

      // Free-running time base: a pulse every 4th cycle
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         check_output("tick_run", 32'(tick_en), (k % 4 == 0) ? 32'd1 : 32'd0);
      end
      check_output("run_mode", 32'(mode), 32'd0);

      // Set the time from 10:20 to 13:05 and load it
      next_cycle();
      cur_hh = 5'd10;
      cur_mm = 6'd20;
      cur_ss = 6'd33;
      apply_stimulus(1'b1, 1'b0);
      check_output("enter_set_hr", 32'(mode), 32'd1);
      check_output("capture_hh", 32'(disp_hh), 32'd10);
      check_output("capture_mm", 32'(disp_mm), 32'd20);
      in_set_phase = 1'b1;
      repeat (3) apply_stimulus(1'b0, 1'b1);
      check_output("edit_hh_13", 32'(disp_hh), 32'd13);
      apply_stimulus(1'b1, 1'b0);
      check_output("enter_set_min", 32'(mode), 32'd2);
      repeat (45) apply_stimulus(1'b0, 1'b1);
      check_output("edit_hh_keep", 32'(disp_hh), 32'd13);
      check_output("edit_mm_05", 32'(disp_mm), 32'd5);
      in_set_phase = 1'b0;
      load_q.push_back({5'd13, 6'd5});
      mode_btn = 1'b1;
      next_cycle();
      mode_btn = 1'b0;
      check_output("enter_al_hr", 32'(mode), 32'd3);
      check_output("load_strobe", 32'(load_en), 32'd1);
      gap = 99;
      for (int n = 1; n <= 10; n++) begin
         next_cycle();
         if (tick_en === 1'b1) begin
            gap = n;
            break;
         end
      end
      check_output("first_tick_gap", 32'(gap), 32'd4);

      // Wrap boundaries and mode/inc collision
      cur_hh = 5'd23;
      cur_mm = 6'd59;
      cur_ss = 6'd0;
      apply_stimulus(1'b1, 1'b0);
      apply_stimulus(1'b1, 1'b0);
      check_output("back_to_run", 32'(mode), 32'd0);
      apply_stimulus(1'b1, 1'b0);
      check_output("set_hr_again", 32'(mode), 32'd1);
      check_output("capture_23", 32'(disp_hh), 32'd23);
      apply_stimulus(1'b0, 1'b1);
      check_output("hh_wrap", 32'(disp_hh), 32'd0);
      apply_stimulus(1'b1, 1'b1);
      check_output("collide_mode", 32'(mode), 32'd2);
      check_output("collide_hh", 32'(disp_hh), 32'd0);
      check_output("collide_mm", 32'(disp_mm), 32'd59);
      apply_stimulus(1'b0, 1'b1);
      check_output("mm_wrap", 32'(disp_mm), 32'd0);

      // Auto-repeat: edge plus repeats at 8, 16, 24 held cycles
      inc_btn = 1'b1;
      repeat (30) next_cycle();
      inc_btn = 1'b0;
      next_cycle();
      check_output("repeat_hold", 32'(disp_mm), 32'd4);
      check_output("repeat_mode", 32'(mode), 32'd2);
      apply_stimulus(1'b0, 1'b1);
      check_output("repress", 32'(disp_mm), 32'd5);
      load_q.push_back({5'd0, 6'd5});
      apply_stimulus(1'b1, 1'b0);
      check_output("enter_al_hr2", 32'(mode), 32'd3);

      // Program alarm 07:30
      repeat (7) apply_stimulus(1'b0, 1'b1);
      check_output("al_hh", 32'(disp_hh), 32'd7);
      check_output("al_mm_init", 32'(disp_mm), 32'd0);
      apply_stimulus(1'b1, 1'b0);
      check_output("enter_al_min", 32'(mode), 32'd4);
      repeat (30) apply_stimulus(1'b0, 1'b1);
      check_output("al_mm", 32'(disp_mm), 32'd30);
      cur_hh = 5'd7;
      cur_mm = 6'd29;
      cur_ss = 6'd59;
      apply_stimulus(1'b1, 1'b0);
      check_output("run_after_al", 32'(mode), 32'd0);
      check_output("run_disp_mm", 32'(disp_mm), 32'd29);

      // Alarm fires one cycle after the match and times out after 3 ticks
      alarm_en = 1'b1;
      next_cycle();
      cur_mm = 6'd30;
      cur_ss = 6'd0;
      @(negedge clk);
      check_output("alarm_before", 32'(alarm_out), 32'd0);
      next_cycle();
      check_output("alarm_set", 32'(alarm_out), 32'd1);
      ticks = 0;
      gone  = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (alarm_out === 1'b0) begin
            gone = 1;
            break;
         end
         if (tick_en === 1'b1) ticks++;
      end
      check_output("alarm_timeout", 32'(gone), 32'd1);
      check_output("alarm_ticks", 32'(ticks), 32'd3);
      repeat (3) next_cycle();
      check_output("alarm_stays_off", 32'(alarm_out), 32'd0);

      // Alarm silenced by a mode press, which is consumed
      cur_mm = 6'd29;
      cur_ss = 6'd59;
      next_cycle();
      cur_mm = 6'd30;
      cur_ss = 6'd0;
      next_cycle();
      check_output("alarm_set2", 32'(alarm_out), 32'd1);
      apply_stimulus(1'b1, 1'b0);
      check_output("alarm_btn_clear", 32'(alarm_out), 32'd0);
      check_output("mode_consumed", 32'(mode), 32'd0);

      // Asynchronous reset in the middle of SET_MIN
      alarm_en = 1'b0;
      cur_hh   = 5'd1;
      cur_mm   = 6'd2;
      cur_ss   = 6'd0;
      apply_stimulus(1'b1, 1'b0);
      apply_stimulus(1'b1, 1'b0);
      apply_stimulus(1'b0, 1'b1);
      check_output("pre_rst_mode", 32'(mode), 32'd2);
      check_output("pre_rst_mm", 32'(disp_mm), 32'd3);
      #2 rst = 1'b0;
      #1;
      check_output("async_mode", 32'(mode), 32'd0);
      check_output("async_tick", 32'(tick_en), 32'd0);
      check_output("async_load_en", 32'(load_en), 32'd0);
      check_output("async_load_mm", 32'(load_mm), 32'd0);
      check_output("async_alarm", 32'(alarm_out), 32'd0);
      check_output("async_disp_mm", 32'(disp_mm), 32'd2);
      #3 rst = 1'b1;
      repeat (10) next_cycle();
      check_output("post_rst_mode", 32'(mode), 32'd0);

      check_output("load_pending", 32'(load_q.size()), 32'd0);
      check_output("load_count", 32'(loads_seen), 32'd2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
